// File: rtl/prio_code_display.sv
// Debounced display stage behind the 8-3 priority encoder: filters switch bounce,
// commits a stable {valid, code}, counts commits and drives two seven-segment digits.
module prio_code_display #(
    parameter int DEB_CYC = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] code_in,
    input  logic       valid_in,
    output logic [2:0] code_q,
    output logic       valid_q,
    output logic       chg_pulse,
    output logic [3:0] chg_cnt,
    output logic [7:0] seg_code,
    output logic [7:0] seg_cnt
);

    localparam int SW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [SW-1:0] STAB_MAX = SW'(DEB_CYC - 1);

    logic [3:0]    samp_n;
    logic [3:0]    r_samp_q, r_samp_d;
    logic [SW-1:0] stab_q, stab_d;
    logic [3:0]    commit_q, commit_d;
    logic          pulse_q, pulse_d;
    logic [3:0]    cnt_q, cnt_d;

    // Code bits carry no meaning when nothing is pressed, so they are zeroed
    // to keep idle switch wiggles from looking like a change.
    assign samp_n = {valid_in, valid_in ? code_in : 3'b000};

    always_comb begin
        r_samp_d = r_samp_q;
        stab_d   = stab_q;
        commit_d = commit_q;
        pulse_d  = 1'b0;
        cnt_d    = cnt_q;

        if (samp_n != r_samp_q) begin
            r_samp_d = samp_n;
            stab_d   = '0;
        end else if (stab_q != STAB_MAX) begin
            stab_d = stab_q + SW'(1);
        end

        // Uses the pre-edge sample, so a change on the commit edge only restarts debounce.
        if ((stab_q == STAB_MAX) && (r_samp_q != commit_q)) begin
            commit_d = r_samp_q;
            pulse_d  = 1'b1;
            cnt_d    = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_samp_q <= '0;
            stab_q   <= '0;
            commit_q <= '0;
            pulse_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            r_samp_q <= r_samp_d;
            stab_q   <= stab_d;
            commit_q <= commit_d;
            pulse_q  <= pulse_d;
            cnt_q    <= cnt_d;
        end
    end

    assign valid_q   = commit_q[3];
    assign code_q    = commit_q[2:0];
    assign chg_pulse = pulse_q;
    assign chg_cnt   = cnt_q;

    function automatic logic [7:0] hex_seg(input logic [3:0] v);
        logic [7:0] s;
        case (v)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    // Digit 0 shows the committed code, digit 1 the change count; both decode registered state only.
    logic [3:0] digit_val [2];
    logic [7:0] digit_seg [2];

    assign digit_val[0] = {1'b0, commit_q[2:0]};
    assign digit_val[1] = cnt_q;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_digit
            assign digit_seg[gi] = hex_seg(digit_val[gi]);
        end
    endgenerate

    assign seg_code = commit_q[3] ? digit_seg[0] : 8'hFF;
    assign seg_cnt  = digit_seg[1];

endmodule

// File: tb/tb_prio_code_display.sv
// Directed bench for prio_code_display (DEB_CYC=4): each task drives one scenario
// and checks registered outputs 1 time unit after the rising edge.
module tb_prio_code_display;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] code_in;
    logic       valid_in;
    logic [2:0] code_q;
    logic       valid_q;
    logic       chg_pulse;
    logic [3:0] chg_cnt;
    logic [7:0] seg_code;
    logic [7:0] seg_cnt;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] hex_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    prio_code_display #(.DEB_CYC(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .code_in  (code_in),
        .valid_in (valid_in),
        .code_q   (code_q),
        .valid_q  (valid_q),
        .chg_pulse(chg_pulse),
        .chg_cnt  (chg_cnt),
        .seg_code (seg_code),
        .seg_cnt  (seg_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int pulses;
        rst = 1'b1; code_in = 3'd0; valid_in = 1'b0;
        tick(); tick();
        n_vec++; if (code_q !== 3'd0) begin n_err++; $display("FAIL reset_code_q: got %0d expected 0", code_q); end
        n_vec++; if (valid_q !== 1'b0) begin n_err++; $display("FAIL reset_valid_q: got %b expected 0", valid_q); end
        n_vec++; if (chg_pulse !== 1'b0) begin n_err++; $display("FAIL reset_pulse: got %b expected 0", chg_pulse); end
        n_vec++; if (chg_cnt !== 4'd0) begin n_err++; $display("FAIL reset_cnt: got %0d expected 0", chg_cnt); end
        n_vec++; if (seg_code !== 8'hFF) begin n_err++; $display("FAIL reset_seg_code: got %h expected ff", seg_code); end
        n_vec++; if (seg_cnt !== 8'hC0) begin n_err++; $display("FAIL reset_seg_cnt: got %h expected c0", seg_cnt); end
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin tick(); if (chg_pulse === 1'b1) pulses++; end
        n_vec++; if (pulses !== 0) begin n_err++; $display("FAIL idle_pulses: got %0d expected 0", pulses); end
        $display("reset/idle done: cnt=%0d seg_code=%h", chg_cnt, seg_code);
    endtask

    task automatic test_clean_change();
        valid_in = 1'b1; code_in = 3'd5;
        for (int i = 0; i < 4; i++) tick();
        n_vec++; if (chg_pulse !== 1'b0) begin n_err++; $display("FAIL clean_early_pulse: got %b expected 0", chg_pulse); end
        tick();
        n_vec++; if (code_q !== 3'd5) begin n_err++; $display("FAIL clean_code_q: got %0d expected 5", code_q); end
        n_vec++; if (valid_q !== 1'b1) begin n_err++; $display("FAIL clean_valid_q: got %b expected 1", valid_q); end
        n_vec++; if (chg_pulse !== 1'b1) begin n_err++; $display("FAIL clean_pulse: got %b expected 1", chg_pulse); end
        n_vec++; if (chg_cnt !== 4'd1) begin n_err++; $display("FAIL clean_cnt: got %0d expected 1", chg_cnt); end
        n_vec++; if (seg_code !== 8'h92) begin n_err++; $display("FAIL clean_seg_code: got %h expected 92", seg_code); end
        n_vec++; if (seg_cnt !== 8'hF9) begin n_err++; $display("FAIL clean_seg_cnt: got %h expected f9", seg_cnt); end
        tick();
        n_vec++; if (chg_pulse !== 1'b0) begin n_err++; $display("FAIL clean_pulse_width: got %b expected 0", chg_pulse); end
        $display("clean change: code_q=%0d cnt=%0d", code_q, chg_cnt);
    endtask

    task automatic test_bounce();
        int pulses;
        int pulse_at;
        pulses = 0; pulse_at = -1;
        for (int s = 0; s < 9; s++) begin
            code_in = (s % 2 == 0) ? 3'd3 : 3'd4;
            tick(); if (chg_pulse === 1'b1) pulses++;
            tick(); if (chg_pulse === 1'b1) pulses++;
        end
        code_in = 3'd4;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (chg_pulse === 1'b1) begin pulses++; if (pulse_at < 0) pulse_at = t; end
        end
        n_vec++; if (pulses !== 1) begin n_err++; $display("FAIL bounce_commits: got %0d expected 1", pulses); end
        n_vec++; if (pulse_at !== 5) begin n_err++; $display("FAIL bounce_latency: got edge %0d expected 5", pulse_at); end
        n_vec++; if (code_q !== 3'd4) begin n_err++; $display("FAIL bounce_code_q: got %0d expected 4", code_q); end
        n_vec++; if (seg_code !== 8'h99) begin n_err++; $display("FAIL bounce_seg_code: got %h expected 99", seg_code); end
        n_vec++; if (chg_cnt !== 4'd2) begin n_err++; $display("FAIL bounce_cnt: got %0d expected 2", chg_cnt); end
        $display("bounce: commits=%0d at edge %0d code_q=%0d", pulses, pulse_at, code_q);
    endtask

    task automatic test_invalid();
        int pulses;
        valid_in = 1'b1; code_in = 3'd7;
        for (int i = 0; i < 5; i++) tick();
        n_vec++; if (seg_code !== 8'hF8) begin n_err++; $display("FAIL inv_pre_seg_code: got %h expected f8", seg_code); end
        valid_in = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        n_vec++; if (chg_pulse !== 1'b1) begin n_err++; $display("FAIL inv_pulse: got %b expected 1", chg_pulse); end
        n_vec++; if (valid_q !== 1'b0) begin n_err++; $display("FAIL inv_valid_q: got %b expected 0", valid_q); end
        n_vec++; if (code_q !== 3'd0) begin n_err++; $display("FAIL inv_code_q: got %0d expected 0", code_q); end
        n_vec++; if (seg_code !== 8'hFF) begin n_err++; $display("FAIL inv_seg_code: got %h expected ff", seg_code); end
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            code_in = (i < 6) ? 3'd2 : 3'd5;
            tick(); if (chg_pulse === 1'b1) pulses++;
        end
        n_vec++; if (pulses !== 0) begin n_err++; $display("FAIL inv_idle_pulses: got %0d expected 0", pulses); end
        n_vec++; if (chg_cnt !== 4'd4) begin n_err++; $display("FAIL inv_cnt: got %0d expected 4", chg_cnt); end
        $display("invalid: valid_q=%b cnt=%0d", valid_q, chg_cnt);
    endtask

    task automatic test_wrap_revert();
        logic [3:0] exp_cnt;
        logic [2:0] exp_code;
        int pulses;
        valid_in = 1'b1;
        for (int k = 0; k < 16; k++) begin
            exp_code = 3'(k % 8);
            exp_cnt  = 4'((5 + k) % 16);
            code_in = exp_code;
            for (int i = 0; i < 4; i++) tick();
            n_vec++; if (chg_pulse !== 1'b0) begin n_err++; $display("FAIL wrap_early_pulse[%0d]: got %b expected 0", k, chg_pulse); end
            tick();
            n_vec++; if (chg_pulse !== 1'b1) begin n_err++; $display("FAIL wrap_pulse[%0d]: got %b expected 1", k, chg_pulse); end
            n_vec++; if (chg_cnt !== exp_cnt) begin n_err++; $display("FAIL wrap_cnt[%0d]: got %0d expected %0d", k, chg_cnt, exp_cnt); end
            n_vec++; if (seg_cnt !== hex_tbl[exp_cnt]) begin n_err++; $display("FAIL wrap_seg_cnt[%0d]: got %h expected %h", k, seg_cnt, hex_tbl[exp_cnt]); end
            n_vec++; if (seg_code !== hex_tbl[{1'b0, exp_code}]) begin n_err++; $display("FAIL wrap_seg_code[%0d]: got %h expected %h", k, seg_code, hex_tbl[{1'b0, exp_code}]); end
            if (exp_cnt == 4'd0) begin
                n_vec++; if (seg_cnt !== 8'hC0) begin n_err++; $display("FAIL wrap_zero_seg: got %h expected c0", seg_cnt); end
            end
            $display("commit %0d: code_q=%0d cnt=%0d seg_cnt=%h", k, code_q, chg_cnt, seg_cnt);
        end
        code_in = 3'd2;
        tick(); tick();
        code_in = 3'd7;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin tick(); if (chg_pulse === 1'b1) pulses++; end
        n_vec++; if (pulses !== 0) begin n_err++; $display("FAIL revert_pulses: got %0d expected 0", pulses); end
        n_vec++; if (chg_cnt !== 4'd4) begin n_err++; $display("FAIL revert_cnt: got %0d expected 4", chg_cnt); end
        n_vec++; if (code_q !== 3'd7) begin n_err++; $display("FAIL revert_code_q: got %0d expected 7", code_q); end
        $display("revert: pulses=%0d cnt=%0d", pulses, chg_cnt);
    endtask

    task automatic test_back_to_back();
        code_in = 3'd1;
        for (int i = 0; i < 4; i++) tick();
        code_in = 3'd6;
        tick();
        n_vec++; if (chg_pulse !== 1'b1) begin n_err++; $display("FAIL b2b_first_pulse: got %b expected 1", chg_pulse); end
        n_vec++; if (code_q !== 3'd1) begin n_err++; $display("FAIL b2b_first_code: got %0d expected 1", code_q); end
        tick();
        n_vec++; if (chg_pulse !== 1'b0) begin n_err++; $display("FAIL b2b_gap: got %b expected 0", chg_pulse); end
        tick(); tick();
        n_vec++; if (chg_pulse !== 1'b0) begin n_err++; $display("FAIL b2b_early: got %b expected 0", chg_pulse); end
        tick();
        n_vec++; if (chg_pulse !== 1'b1) begin n_err++; $display("FAIL b2b_second_pulse: got %b expected 1", chg_pulse); end
        n_vec++; if (code_q !== 3'd6) begin n_err++; $display("FAIL b2b_second_code: got %0d expected 6", code_q); end
        n_vec++; if (chg_cnt !== 4'd6) begin n_err++; $display("FAIL b2b_cnt: got %0d expected 6", chg_cnt); end
        $display("back-to-back: code_q=%0d cnt=%0d", code_q, chg_cnt);
    endtask

    task automatic test_reset_mid();
        code_in = 3'd3;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++; if (chg_cnt !== 4'd0) begin n_err++; $display("FAIL rmid_cnt_clear: got %0d expected 0", chg_cnt); end
        n_vec++; if (valid_q !== 1'b0) begin n_err++; $display("FAIL rmid_valid_clear: got %b expected 0", valid_q); end
        for (int i = 0; i < 4; i++) tick();
        n_vec++; if (chg_pulse !== 1'b0) begin n_err++; $display("FAIL rmid_early_pulse: got %b expected 0", chg_pulse); end
        tick();
        n_vec++; if (chg_pulse !== 1'b1) begin n_err++; $display("FAIL rmid_pulse: got %b expected 1", chg_pulse); end
        n_vec++; if (code_q !== 3'd3) begin n_err++; $display("FAIL rmid_code_q: got %0d expected 3", code_q); end
        n_vec++; if (chg_cnt !== 4'd1) begin n_err++; $display("FAIL rmid_cnt: got %0d expected 1", chg_cnt); end
        n_vec++; if (seg_code !== 8'hB0) begin n_err++; $display("FAIL rmid_seg_code: got %h expected b0", seg_code); end
        $display("reset mid-debounce: code_q=%0d cnt=%0d", code_q, chg_cnt);
    endtask

    initial begin
        test_reset();
        test_clean_change();
        test_bounce();
        test_invalid();
        test_wrap_revert();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
